hram_seq: RTL and testbench
===========================

# hram_seq

Transaction sequencer for the HyperRAM controller: accepts read and write burst commands and drives the HyperRAM pins one byte per `clk`. That is one byte per CK edge, so CK runs at half the `clk` rate. It produces `cs_n`, `ck_out`, `dq_out`/`dq_oe` and `rwds_out`/`rwds_oe`, which feed the tri-state IO buffer stage directly, and it consumes `dq_in`/`rwds_in` returned from that stage. It also handles CA generation, fixed 2x initial latency, the write data phase, RWDS-strobed read capture, and CS# recovery.

## Interface
- LATENCY_CLKS, 6: device initial latency in CK cycles; fixed 2x latency is always applied.
- BURST_W, 5: width of `cmd_len`; a burst is `cmd_len+1` 16-bit words.
- RD_TIMEOUT, 64: maximum `clk` cycles between RWDS edges during a read before abort.
- clk  in  1  system clock, 2x HyperRAM CK rate
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_rw  in  1  1 = read, 0 = write
- cmd_addr  in  32  word address
- cmd_len  in  BURST_W  word count minus 1
- wr_req  out  1  pulse: `wr_data` sampled this cycle
- wr_data  in  16  write word, MSB byte sent first
- rd_data  out  16  read word
- rd_valid  out  1  one-cycle strobe per read word
- done  out  1  one-cycle pulse at end of each command
- err  out  1  one-cycle pulse on read timeout
- cs_n, ck_out  out  1 each  device chip select, clock
- dq_out  out  8; dq_oe  out  1; dq_in  in  8
- rwds_out  out  1; rwds_oe  out  1; rwds_in  in  1

## Operation
- **States and transitions:**
  - IDLE → CA on `cmd_valid && cmd_ready`.
  - CA (6 cycles) → LAT (4·LATENCY_CLKS cycles).
  - LAT → WDATA or RDATA.
  - WDATA or RDATA → END (2 cycles) → RECOV (4 cycles) → IDLE.
- **Command capture:** the command is latched at acceptance. `cmd_*` inputs are ignored outside IDLE.
- **CA word** (48 bits, sent as bytes [47:40] first … [7:0] last):
  - bit47 = `cmd_rw`, bit46 = 0 (memory space), bit45 = 1 (linear burst).
  - [44:16] = `addr[31:3]`, [15:3] = 0, [2:0] = `addr[2:0]`.
- **Clock:** `ck_out` = 0 whenever `cs_n` = 1. In CA/LAT/WDATA/RDATA, `ck_out` = 1 in even slot cycles and 0 in odd ones, counted from the first CA cycle, so it toggles every `clk`. In END, `ck_out` = 0.
- **CA phase:** `dq_oe` = 1, `rwds_oe` = 0.
- **LAT phase:** `dq_oe` = 0, `rwds_oe` = 0. RWDS edges are ignored.
- **WDATA phase:**
  - `dq_oe` = 1, `rwds_oe` = 1, `rwds_out` = 0 (no masking).
  - `wr_req` pulses in the last LAT cycle and then every second cycle.
  - The word sampled at `wr_req` is driven high byte in the next cycle, low byte in the one after.
  - Exactly `cmd_len+1` pulses per command.
- **RDATA phase:**
  - `dq_oe` = 0, `rwds_oe` = 0.
  - `rwds_in` is registered. A byte is captured on every cycle where `rwds_in` differs from its registered value.
  - Bytes pair up high byte first. `rd_valid` pulses one cycle after each low byte is captured.
  - Ends after `cmd_len+1` words.
  - If RD_TIMEOUT cycles pass without an RWDS edge: go to END, pulse `err`, emit no further `rd_valid`.
- **END:** `cs_n` stays 0 with `ck_out` held low; `dq_oe` = 0.
- **RECOV:** `cs_n` = 1. `done` pulses in the first RECOV cycle.

## Timing
- **Reset values** (applied at the first `clk` edge with `rst` = 1, in any state, including mid-burst):
  - `cs_n` = 1.
  - `ck_out`, `dq_out`, `dq_oe`, `rwds_out`, `rwds_oe`, `wr_req`, `rd_valid`, `rd_data`, `done`, `err` = 0.
  - `cmd_ready` = 0.
  - State = IDLE; `cmd_ready` = 1 in the first cycle after `rst` deasserts.
- **Cycle numbering:** the command is accepted at edge T.
  - T+1..T+6: CA bytes, `cs_n` = 0.
  - T+7..T+6+4L: latency, with L = LATENCY_CLKS.
  - First write data byte at T+7+4L.
- **Write burst of N words:** data occupies 2N cycles, then END and RECOV. `cs_n` is low for 6+4L+2N+2 cycles.
- **Back-to-back commands:** `cs_n` is high for a minimum of 4 cycles between commands.
- **No overlap:** `rd_valid` and `wr_req` never assert in the same command.

## Test plan
- **Write, 2 words:** `cmd_addr`=0x00000005, `cmd_len`=1, L=6, `wr_data` 0xA1B2 then 0xC3D4.
  - CA bytes 00 20 00 00 00 05.
  - `wr_req` at T+30 and T+32.
  - `dq_out` A1,B2,C3,D4 at T+31..T+34.
  - `cs_n` low T+1..T+36; `done` at T+37.
- **Read, 3 words:** RWDS toggling every cycle with bytes 11..66.
  - `rd_data` 0x1122, 0x3344, 0x5566 on three `rd_valid` strobes.
  - CA byte 0 = 0xA0.
- **Read timeout:** `rwds_in` held constant.
  - `err` pulses RD_TIMEOUT cycles after LAT ends.
  - Zero `rd_valid`; `done` follows; `cmd_ready` returns after RECOV.
- **Reset mid-write:** `rst` asserted during WDATA.
  - `cs_n` = 1, `dq_oe` = 0, `wr_req` = 0 at the next edge.
  - A new command is accepted cleanly afterwards.
- **Max burst with back-to-back commands:** `cmd_len`=31 write then read, `cmd_valid` held high.
  - Exactly 32 `wr_req` pulses.
  - `cs_n` high ≥ 4 cycles between bursts.
  - RWDS edges during LAT are ignored.

Source files
------------

// File: rtl/hram_seq.sv
// HyperRAM transaction sequencer: turns read/write burst commands into CS#/CK/DQ/RWDS
// pin activity, one byte per clk, with fixed 2x initial latency and RWDS-strobed reads.
module hram_seq #(
   parameter int LATENCY_CLKS = 6,
   parameter int BURST_W      = 5,
   parameter int RD_TIMEOUT   = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_rw,
   input  logic [31:0]        cmd_addr,
   input  logic [BURST_W-1:0] cmd_len,
   output logic               wr_req,
   input  logic [15:0]        wr_data,
   output logic [15:0]        rd_data,
   output logic               rd_valid,
   output logic               done,
   output logic               err,
   output logic               cs_n,
   output logic               ck_out,
   output logic [7:0]         dq_out,
   output logic               dq_oe,
   input  logic [7:0]         dq_in,
   output logic               rwds_out,
   output logic               rwds_oe,
   input  logic               rwds_in
);
   localparam int LAT_CYC = 4 * LATENCY_CLKS;
   localparam int CNT_W   = $clog2(LAT_CYC + 6);
   localparam int TO_W    = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CA, S_LAT, S_WDATA, S_RDATA, S_END, S_RECOV
   } state_t;

   typedef struct packed {
      logic               rw;
      logic [BURST_W-1:0] len;
   } cmd_t;

   state_t             state;
   cmd_t               cmd;
   logic [CNT_W-1:0]   cnt;
   logic [47:0]        ca_sr;
   logic [BURST_W-1:0] wcnt;
   logic               byte_sel;
   logic [7:0]         hold;
   logic               rwds_q;
   logic [TO_W-1:0]    to_cnt;
   logic               rwds_edge;

   assign rwds_edge = rwds_in ^ rwds_q;

   // Outputs are registered from the current state, so pins trail the state by one clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cmd       <= '0;
         cnt       <= '0;
         ca_sr     <= '0;
         wcnt      <= '0;
         byte_sel  <= 1'b0;
         hold      <= '0;
         rwds_q    <= 1'b0;
         to_cnt    <= '0;
         cmd_ready <= 1'b0;
         cs_n      <= 1'b1;
         ck_out    <= 1'b0;
         dq_out    <= '0;
         dq_oe     <= 1'b0;
         rwds_out  <= 1'b0;
         rwds_oe   <= 1'b0;
         wr_req    <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         rwds_q   <= rwds_in;
         wr_req   <= 1'b0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         rwds_out <= 1'b0;
         ck_out   <= ~ck_out;
         cnt      <= cnt + 1'b1;
         case (state)
            S_IDLE: begin
               cs_n      <= 1'b1;
               ck_out    <= 1'b0;
               dq_out    <= '0;
               dq_oe     <= 1'b0;
               rwds_oe   <= 1'b0;
               cnt       <= '0;
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  cmd.rw    <= cmd_rw;
                  cmd.len   <= cmd_len;
                  ca_sr     <= {cmd_rw, 1'b0, 1'b1, cmd_addr[31:3], 13'd0, cmd_addr[2:0]};
                  state     <= S_CA;
               end
            end
            S_CA: begin
               cs_n    <= 1'b0;
               dq_oe   <= 1'b1;
               rwds_oe <= 1'b0;
               dq_out  <= ca_sr[47:40];
               ca_sr   <= {ca_sr[39:0], 8'h00};
               // CK phase is anchored here: first CA byte goes out with CK high
               if (cnt == '0) ck_out <= 1'b1;
               if (cnt == CNT_W'(5)) begin
                  cnt   <= '0;
                  state <= S_LAT;
               end
            end
            S_LAT: begin
               cs_n    <= 1'b0;
               dq_out  <= '0;
               dq_oe   <= 1'b0;
               rwds_oe <= 1'b0;
               if (cnt == CNT_W'(LAT_CYC - 1)) begin
                  cnt      <= '0;
                  wcnt     <= '0;
                  byte_sel <= 1'b0;
                  to_cnt   <= '0;
                  if (cmd.rw) begin
                     state <= S_RDATA;
                  end else begin
                     wr_req <= 1'b1;
                     state  <= S_WDATA;
                  end
               end
            end
            S_WDATA: begin
               cs_n     <= 1'b0;
               dq_oe    <= 1'b1;
               rwds_oe  <= 1'b1;
               byte_sel <= ~byte_sel;
               if (!byte_sel) begin
                  dq_out <= wr_data[15:8];
                  hold   <= wr_data[7:0];
               end else begin
                  dq_out <= hold;
                  if (wcnt == cmd.len) begin
                     cnt   <= '0;
                     state <= S_END;
                  end else begin
                     wr_req <= 1'b1;
                     wcnt   <= wcnt + 1'b1;
                  end
               end
            end
            S_RDATA: begin
               cs_n    <= 1'b0;
               dq_oe   <= 1'b0;
               rwds_oe <= 1'b0;
               if (rwds_edge) begin
                  to_cnt   <= '0;
                  byte_sel <= ~byte_sel;
                  if (!byte_sel) begin
                     hold <= dq_in;
                  end else begin
                     rd_data  <= {hold, dq_in};
                     rd_valid <= 1'b1;
                     if (wcnt == cmd.len) begin
                        cnt   <= '0;
                        state <= S_END;
                     end else begin
                        wcnt <= wcnt + 1'b1;
                     end
                  end
               end else if (to_cnt == TO_W'(RD_TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  cnt   <= '0;
                  state <= S_END;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_END: begin
               cs_n    <= 1'b0;
               ck_out  <= 1'b0;
               dq_out  <= '0;
               dq_oe   <= 1'b0;
               rwds_oe <= 1'b0;
               if (cnt == CNT_W'(1)) begin
                  cnt   <= '0;
                  state <= S_RECOV;
               end
            end
            S_RECOV: begin
               cs_n   <= 1'b1;
               ck_out <= 1'b0;
               done   <= (cnt == '0);
               if (cnt == CNT_W'(3)) begin
                  cnt       <= '0;
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hram_seq.sv
// Directed bench for hram_seq: write, read, timeout, reset mid-burst, back-to-back max bursts.
module tb_hram_seq;
   localparam int L  = 6;
   localparam int BW = 5;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_rw = 1'b0;
   logic [31:0]   cmd_addr = '0;
   logic [BW-1:0] cmd_len = '0;
   logic          wr_req;
   logic [15:0]   wr_data = '0;
   logic [15:0]   rd_data;
   logic          rd_valid, done, err, cs_n, ck_out;
   logic [7:0]    dq_out;
   logic          dq_oe;
   logic [7:0]    dq_in = '0;
   logic          rwds_out, rwds_oe;
   logic          rwds_in = 1'b0;

   int cyc = 0;
   int tests = 0;
   int fails = 0;

   hram_seq #(.LATENCY_CLKS(L), .BURST_W(BW), .RD_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_req(wr_req), .wr_data(wr_data),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err), .cs_n(cs_n),
      .ck_out(ck_out), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
      .rwds_out(rwds_out), .rwds_oe(rwds_oe), .rwds_in(rwds_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL global_timeout: sim time exceeded, want completion");
      $fatal(1);
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++;
      if (cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
      tests++;
      if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
      tests++;
      if ({ck_out, dq_oe, rwds_out, rwds_oe, wr_req, rd_valid, done, err} !== 8'h00) begin
         fails++;
         $display("FAIL reset_ctl: got %b want 00000000", {ck_out, dq_oe, rwds_out, rwds_oe, wr_req, rd_valid, done, err});
      end
      tests++;
      if ({dq_out, rd_data} !== 24'h0) begin fails++; $display("FAIL reset_data: got %h want 000000", {dq_out, rd_data}); end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_write();
      int t0, k, wi;
      bit ok;
      logic [7:0]  ca [6];
      logic [7:0]  dx [4];
      logic [15:0] wd [2];
      ca = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05};
      dx = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      wd = '{16'hA1B2, 16'hC3D4};
      wait_ready(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL write_ready: got 0 want 1"); return; end
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h5; cmd_len = 5'd1;
      @(negedge clk);
      cmd_valid = 1'b0; t0 = cyc; wi = 0;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         tests++;
         if (cs_n !== ((k <= 36) ? 1'b0 : 1'b1)) begin fails++; $display("FAIL write_cs_n k=%0d: got %b", k, cs_n); end
         tests++;
         if (done !== (k == 37)) begin fails++; $display("FAIL write_done k=%0d: got %b", k, done); end
         tests++;
         if (wr_req !== (k == 30 || k == 32)) begin fails++; $display("FAIL write_wr_req k=%0d: got %b", k, wr_req); end
         tests++;
         if ((k <= 34 ? k[0] : 1'b0) !== ck_out) begin fails++; $display("FAIL write_ck k=%0d: got %b", k, ck_out); end
         if ({rd_valid, err} !== 2'b00) begin tests++; fails++; $display("FAIL write_rd_err k=%0d: got %b want 00", k, {rd_valid, err}); end
         if (k <= 6) begin
            tests++;
            if (dq_out !== ca[k-1] || dq_oe !== 1'b1 || rwds_oe !== 1'b0) begin
               fails++; $display("FAIL write_ca k=%0d: got %h oe=%b want %h", k, dq_out, dq_oe, ca[k-1]);
            end
         end else if (k <= 30) begin
            tests++;
            if (dq_oe !== 1'b0 || rwds_oe !== 1'b0) begin fails++; $display("FAIL write_lat_oe k=%0d: got %b%b want 00", k, dq_oe, rwds_oe); end
         end else if (k <= 34) begin
            tests++;
            if (dq_out !== dx[k-31] || dq_oe !== 1'b1 || rwds_oe !== 1'b1 || rwds_out !== 1'b0) begin
               fails++; $display("FAIL write_data k=%0d: got %h want %h", k, dq_out, dx[k-31]);
            end
         end else if (k <= 36) begin
            tests++;
            if (dq_oe !== 1'b0) begin fails++; $display("FAIL write_end_oe k=%0d: got %b want 0", k, dq_oe); end
         end else begin
            tests++;
            if (cmd_ready !== (k >= 40)) begin fails++; $display("FAIL write_ready_ret k=%0d: got %b", k, cmd_ready); end
         end
         if (wr_req) begin
            wr_data = (wi < 2) ? wd[wi] : 16'h0000;
            wi++;
         end
      end
   endtask

   task automatic test_read();
      int t0, k, nrv;
      bit ok;
      logic [7:0]  ca [6];
      logic [15:0] er [3];
      ca = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
      er = '{16'h1122, 16'h3344, 16'h5566};
      nrv = 0;
      wait_ready(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL read_ready: got 0 want 1"); return; end
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 32'h2; cmd_len = 5'd2;
      @(negedge clk);
      cmd_valid = 1'b0; t0 = cyc;
      for (k = 1; k <= 42; k++) begin
         @(negedge clk);
         if (k <= 6) begin
            tests++;
            if (dq_out !== ca[k-1]) begin fails++; $display("FAIL read_ca k=%0d: got %h want %h", k, dq_out, ca[k-1]); end
         end
         if (k >= 7 && dq_oe !== 1'b0) begin tests++; fails++; $display("FAIL read_dq_oe k=%0d: got 1 want 0", k); end
         tests++;
         if (rd_valid !== (k == 32 || k == 34 || k == 36)) begin fails++; $display("FAIL read_valid k=%0d: got %b", k, rd_valid); end
         if (rd_valid === 1'b1 && nrv < 3) begin
            tests++;
            if (rd_data !== er[nrv]) begin fails++; $display("FAIL read_data w%0d: got %h want %h", nrv, rd_data, er[nrv]); end
            nrv++;
         end
         tests++;
         if (cs_n !== ((k <= 38) ? 1'b0 : 1'b1)) begin fails++; $display("FAIL read_cs_n k=%0d: got %b", k, cs_n); end
         tests++;
         if (done !== (k == 39)) begin fails++; $display("FAIL read_done k=%0d: got %b", k, done); end
         if ({wr_req, err} !== 2'b00) begin tests++; fails++; $display("FAIL read_wr_err k=%0d: got %b want 00", k, {wr_req, err}); end
         if (k == 41 || k == 42) begin
            tests++;
            if (cmd_ready !== (k == 42)) begin fails++; $display("FAIL read_ready_ret k=%0d: got %b", k, cmd_ready); end
         end
         if (k >= 30 && k <= 35) begin
            dq_in   = 8'(8'h11 * (k - 29));
            rwds_in = ~rwds_in;
         end
      end
   endtask

   task automatic test_timeout();
      int t0, k;
      bit ok;
      wait_ready(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL to_ready: got 0 want 1"); return; end
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 32'h40; cmd_len = 5'd0;
      @(negedge clk);
      cmd_valid = 1'b0; t0 = cyc;
      for (k = 1; k <= 101; k++) begin
         @(negedge clk);
         tests++;
         if (err !== (k == 30 + TO)) begin fails++; $display("FAIL to_err k=%0d: got %b", k, err); end
         tests++;
         if (done !== (k == 33 + TO)) begin fails++; $display("FAIL to_done k=%0d: got %b", k, done); end
         if (rd_valid !== 1'b0) begin tests++; fails++; $display("FAIL to_rd_valid k=%0d: got 1 want 0", k); end
         if (k >= 95) begin
            tests++;
            if (cs_n !== (k >= 97)) begin fails++; $display("FAIL to_cs_n k=%0d: got %b", k, cs_n); end
            tests++;
            if (cmd_ready !== (k >= 100)) begin fails++; $display("FAIL to_ready_ret k=%0d: got %b", k, cmd_ready); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int t0, k, nwr;
      bit ok;
      logic [7:0] ca [6];
      ca = '{8'h20, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
      wait_ready(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL rmid_ready: got 0 want 1"); return; end
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h100; cmd_len = 5'd3;
      @(negedge clk);
      cmd_valid = 1'b0; t0 = cyc;
      for (k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (wr_req) wr_data = 16'h5A00 + 16'(k);
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (cs_n !== 1'b1 || dq_oe !== 1'b0 || wr_req !== 1'b0) begin
         fails++; $display("FAIL rmid_pins: got cs_n=%b dq_oe=%b wr_req=%b want 1 0 0", cs_n, dq_oe, wr_req);
      end
      tests++;
      if (cmd_ready !== 1'b0 || ck_out !== 1'b0 || rwds_oe !== 1'b0) begin
         fails++; $display("FAIL rmid_ctl: got rdy=%b ck=%b rwds_oe=%b want 0 0 0", cmd_ready, ck_out, rwds_oe);
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready_after: got %b want 1", cmd_ready); end
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h8; cmd_len = 5'd0;
      @(negedge clk);
      cmd_valid = 1'b0; t0 = cyc; nwr = 0;
      for (k = 1; k <= 36; k++) begin
         @(negedge clk);
         if (k <= 6) begin
            tests++;
            if (dq_out !== ca[k-1]) begin fails++; $display("FAIL rmid_ca k=%0d: got %h want %h", k, dq_out, ca[k-1]); end
         end
         if (k == 31 || k == 32) begin
            tests++;
            if (dq_out !== ((k == 31) ? 8'hBE : 8'hEF)) begin fails++; $display("FAIL rmid_data k=%0d: got %h", k, dq_out); end
         end
         tests++;
         if (done !== (k == 35)) begin fails++; $display("FAIL rmid_done k=%0d: got %b", k, done); end
         if (wr_req) begin
            nwr++;
            wr_data = 16'hBEEF;
         end
      end
      tests++;
      if (nwr != 1) begin fails++; $display("FAIL rmid_wr_count: got %0d want 1", nwr); end
   endtask

   task automatic test_back_to_back();
      int k, t1, naccept, nwr, nrv, ndone, nruns, lo_len, hi_len, min_gap, bad_overlap;
      int run_len [2];
      bit ok, pend, prev_cs, fin;
      logic [15:0] ew;
      naccept = 1; t1 = -1000; nwr = 0; nrv = 0; ndone = 0; nruns = 0;
      lo_len = 0; hi_len = 0; min_gap = 1000; bad_overlap = 0; prev_cs = 1'b1;
      run_len = '{0, 0}; pend = 1'b1; fin = 1'b0;
      wait_ready(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL b2b_ready: got 0 want 1"); return; end
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h200; cmd_len = 5'd31;
      for (int i = 0; i < 600 && !fin; i++) begin
         @(negedge clk);
         if (pend) begin
            pend = 1'b0;
            if (naccept == 1) begin cmd_rw = 1'b1; cmd_addr = 32'h300; end
            else cmd_valid = 1'b0;
         end
         k = cyc - t1;
         if (wr_req) begin
            nwr++;
            if (naccept >= 2) bad_overlap++;
            wr_data = 16'hA000 + 16'(nwr);
         end
         if (rd_valid) begin
            if (naccept < 2 || k < 31) bad_overlap++;
            ew = {8'(2 * nrv), 8'(2 * nrv + 1)};
            tests++;
            if (rd_data !== ew) begin fails++; $display("FAIL b2b_rd_data w%0d: got %h want %h", nrv, rd_data, ew); end
            nrv++;
         end
         if (done) ndone++;
         if (!cs_n) begin
            if (prev_cs && nruns > 0 && hi_len < min_gap) min_gap = hi_len;
            lo_len++;
         end else begin
            if (!prev_cs) begin
               if (nruns < 2) run_len[nruns] = lo_len;
               nruns++; lo_len = 0; hi_len = 0;
            end
            hi_len++;
         end
         prev_cs = cs_n;
         if (cmd_valid && cmd_ready) begin
            naccept++;
            pend = 1'b1;
            if (naccept == 2) t1 = cyc + 1;
         end
         if (naccept >= 2 && k >= 7 && k <= 29) begin
            dq_in = 8'hEE; rwds_in = ~rwds_in;
         end else if (naccept >= 2 && k >= 30 && k <= 93) begin
            dq_in = 8'(k - 30); rwds_in = ~rwds_in;
         end
         if (ndone == 2 && cmd_ready) fin = 1'b1;
      end
      cmd_valid = 1'b0;
      tests++;
      if (!fin) begin fails++; $display("FAIL b2b_complete: got done=%0d want 2 within bound", ndone); end
      tests++;
      if (naccept != 2) begin fails++; $display("FAIL b2b_accepts: got %0d want 2", naccept); end
      tests++;
      if (nwr != 32) begin fails++; $display("FAIL b2b_wr_req: got %0d want 32", nwr); end
      tests++;
      if (nrv != 32) begin fails++; $display("FAIL b2b_rd_valid: got %0d want 32", nrv); end
      tests++;
      if (ndone != 2) begin fails++; $display("FAIL b2b_done: got %0d want 2", ndone); end
      tests++;
      if (bad_overlap != 0) begin fails++; $display("FAIL b2b_overlap: got %0d want 0", bad_overlap); end
      tests++;
      if (min_gap < 4 || min_gap >= 1000) begin fails++; $display("FAIL b2b_gap: got %0d want >=4", min_gap); end
      tests++;
      if (run_len[0] != 96 || run_len[1] != 96) begin
         fails++; $display("FAIL b2b_cs_low: got %0d,%0d want 96,96", run_len[0], run_len[1]);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
